// File: rtl/winograd_pkg.sv
// Shared definitions for the Winograd F(2x2,3x3) datapath: tile geometry and
// the 4x4 element packing used by both the tile extractor and data transform.
package winograd_pkg;

    localparam int unsigned W_DEFAULT   = 8;
    localparam int unsigned TILE_N      = 4;
    localparam int unsigned TILE_STRIDE = 2;

    typedef enum logic [0:0] {
        StFill,
        StEmit
    } ext_state_e;

    // Element (i,j) of a packed tile lives at bits [elem_idx(i,j)*W +: W].
    function automatic int unsigned elem_idx(input int unsigned i, input int unsigned j);
        return TILE_N * i + j;
    endfunction

endpackage

// File: rtl/winograd_line_buffer.sv
// Four-row circular line buffer with one write port and a combinational 4x4
// window read. The window forwards a same-cycle write so a tile can be
// captured on the very edge that stores its final pixel.
module winograd_line_buffer
    import winograd_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned IMG_W = 8,
    localparam int unsigned CW   = $clog2(IMG_W)
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [1:0]                 wr_row_i,
    input  logic [CW-1:0]              wr_col_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic [1:0]                 base_i,
    input  logic [CW-1:0]              col_i,
    output logic [TILE_N*TILE_N*W-1:0] window_o
);

    logic [W-1:0] mem_q [TILE_N][IMG_W];
    logic [1:0]    prow;
    logic [CW-1:0] pcol;

    // Pixel storage; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_row_i][wr_col_i] <= wr_data_i;
        end
    end

    // 4x4 window at logical rows 0..3 (physical base+i mod 4), cols col..col+3.
    always_comb begin
        window_o = '0;
        prow     = '0;
        pcol     = '0;
        for (int i = 0; i < TILE_N; i++) begin
            for (int j = 0; j < TILE_N; j++) begin
                prow = base_i + 2'(i);
                pcol = col_i + CW'(j);
                if (we_i && (wr_row_i == prow) && (wr_col_i == pcol)) begin
                    window_o[elem_idx(i, j)*W +: W] = wr_data_i;
                end else begin
                    window_o[elem_idx(i, j)*W +: W] = mem_q[prow][pcol];
                end
            end
        end
    end

endmodule

// File: rtl/winograd_tile_extractor.sv
// Converts a raster pixel stream into overlapping 4x4 tiles at stride 2 for the
// Winograd data-transform stage. Fills a band of rows, then emits its tiles.
module winograd_tile_extractor
    import winograd_pkg::*;
#(
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned IMG_W = 8,
    parameter int unsigned IMG_H = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic [W-1:0]               pix_data,
    output logic                       tile_valid,
    input  logic                       tile_ready,
    output logic [TILE_N*TILE_N*W-1:0] tile_data,
    output logic [7:0]                 tile_row,
    output logic [7:0]                 tile_col,
    output logic                       tile_last
);

    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned TW  = TILE_N * TILE_N * W;
    localparam int unsigned TPB = (IMG_W - TILE_STRIDE) / TILE_STRIDE;
    localparam int unsigned NB  = (IMG_H - TILE_STRIDE) / TILE_STRIDE;

    ext_state_e    state_q, state_d;
    logic [1:0]    base_q, base_d;
    logic [7:0]    band_q, band_d;
    logic [7:0]    tidx_q, tidx_d;
    logic [CW-1:0] wr_col_q, wr_col_d;
    logic [2:0]    rows_q, rows_d;
    logic          tile_valid_q, tile_valid_d;
    logic [TW-1:0] tile_data_q, tile_data_d;
    logic [7:0]    tile_row_q, tile_row_d;
    logic [7:0]    tile_col_q, tile_col_d;
    logic          tile_last_q, tile_last_d;

    logic          we;
    logic [1:0]    wr_row;
    logic [1:0]    lrow;
    logic [CW-1:0] rd_col;
    logic [2:0]    rows_need;
    logic [TW-1:0] window;

    winograd_line_buffer #(
        .W     (W),
        .IMG_W (IMG_W)
    ) u_line_buffer (
        .clk_i     (clk),
        .we_i      (we),
        .wr_row_i  (wr_row),
        .wr_col_i  (wr_col_q),
        .wr_data_i (pix_data),
        .base_i    (base_q),
        .col_i     (rd_col),
        .window_o  (window)
    );

    // Pixel-side handshake, write addressing and window column select.
    always_comb begin
        pix_ready = (state_q == StFill) && !rst;
        we        = pix_valid && pix_ready;
        rows_need = (band_q == 8'd0) ? 3'd4 : 3'd2;
        // First band fills logical rows 0..3; later bands refill rows 2..3.
        lrow      = (band_q == 8'd0) ? rows_q[1:0] : rows_q[1:0] + 2'd2;
        wr_row    = base_q + lrow;
        rd_col    = '0;
        if ((state_q == StEmit) && (tidx_q != 8'(TPB - 1))) begin
            rd_col = CW'(TILE_STRIDE * (int'(tidx_q) + 1));
        end
    end

    // Next-state: band fill counting, tile stepping and output register loads.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        band_d       = band_q;
        tidx_d       = tidx_q;
        wr_col_d     = wr_col_q;
        rows_d       = rows_q;
        tile_valid_d = tile_valid_q;
        tile_data_d  = tile_data_q;
        tile_row_d   = tile_row_q;
        tile_col_d   = tile_col_q;
        tile_last_d  = tile_last_q;
        unique case (state_q)
            StFill: begin
                if (we) begin
                    if (wr_col_q == CW'(IMG_W - 1)) begin
                        wr_col_d = '0;
                        if (rows_q + 3'd1 == rows_need) begin
                            rows_d       = '0;
                            state_d      = StEmit;
                            tidx_d       = '0;
                            tile_valid_d = 1'b1;
                            tile_data_d  = window;
                            tile_row_d   = band_q;
                            tile_col_d   = '0;
                            tile_last_d  = (band_q == 8'(NB - 1)) && (TPB == 1);
                        end else begin
                            rows_d = rows_q + 3'd1;
                        end
                    end else begin
                        wr_col_d = wr_col_q + CW'(1);
                    end
                end
            end
            StEmit: begin
                if (tile_valid_q && tile_ready) begin
                    if (tidx_q == 8'(TPB - 1)) begin
                        tile_valid_d = 1'b0;
                        tile_last_d  = 1'b0;
                        state_d      = StFill;
                        if (band_q == 8'(NB - 1)) begin
                            band_d = '0;
                            base_d = '0;
                        end else begin
                            band_d = band_q + 8'd1;
                            // Two oldest physical rows become the refill target.
                            base_d = base_q + 2'd2;
                        end
                    end else begin
                        tidx_d      = tidx_q + 8'd1;
                        tile_data_d = window;
                        tile_col_d  = tidx_q + 8'd1;
                        tile_last_d = (band_q == 8'(NB - 1)) && (tidx_q + 8'd1 == 8'(TPB - 1));
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StFill;
            base_q       <= '0;
            band_q       <= '0;
            tidx_q       <= '0;
            wr_col_q     <= '0;
            rows_q       <= '0;
            tile_valid_q <= 1'b0;
            tile_data_q  <= '0;
            tile_row_q   <= '0;
            tile_col_q   <= '0;
            tile_last_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            band_q       <= band_d;
            tidx_q       <= tidx_d;
            wr_col_q     <= wr_col_d;
            rows_q       <= rows_d;
            tile_valid_q <= tile_valid_d;
            tile_data_q  <= tile_data_d;
            tile_row_q   <= tile_row_d;
            tile_col_q   <= tile_col_d;
            tile_last_q  <= tile_last_d;
        end
    end

    assign tile_valid = tile_valid_q;
    assign tile_data  = tile_data_q;
    assign tile_row   = tile_row_q;
    assign tile_col   = tile_col_q;
    assign tile_last  = tile_last_q;

endmodule

// File: doc/winograd_tile_extractor.md
Name: winograd_tile_extractor

Overview:
Input-side producer for the Winograd F(2x2,3x3) datapath. It accepts a raster-order pixel stream of one feature-map channel and emits overlapping 4x4 data tiles at stride 2. Tiles are packed in the 16xW format taken by the 4x4 data-transform stage. A valid/ready handshake sits on both the pixel side and the tile side.

Parameters:
W, 8, pixel width in bits
IMG_W, 8, image width in pixels; even, >=4
IMG_H, 8, image height in pixels; even, >=4

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
pix_valid  input  1  pixel on pix_data is valid
pix_ready  output  1  extractor accepts a pixel this cycle
pix_data  input  W  pixel, raster order (row-major, top-left first)
tile_valid  output  1  tile_data holds a valid tile
tile_ready  input  1  downstream accepts the tile
tile_data  output  16*W  element (i,j) (row i, col j, 0..3) at bits [(4*i+j)*W +: W]
tile_row  output  8  tile row index (top row / 2)
tile_col  output  8  tile column index (left col / 2)
tile_last  output  1  last tile of the frame; qualified by tile_valid

Behaviour:
- Geometry:
  - Tiles per band: TPB = (IMG_W-2)/2.
  - Bands per frame: NB = (IMG_H-2)/2.
  - Tile (b,t) covers image rows 2b..2b+3 and cols 2t..2t+3.
- Storage: 4-row circular line buffer (4*IMG_W*W bits) with a 2-bit base-row pointer. Logical row i maps to physical row (base+i) mod 4.
- FSM states:
  - FILL: pix_ready=1. Each pix_valid&&pix_ready stores the pixel at (write row, write col). The column counter wraps at IMG_W-1 and increments the rows-received count. When the required number of rows is complete (4 for the first band, 2 otherwise), go to EMIT.
  - EMIT: pix_ready=0. Tiles t=0..TPB-1 of band b are presented in order.
    - On tile_valid&&tile_ready the next tile loads the following cycle, giving one tile per cycle when tile_ready is held high.
    - After the handshake of tile TPB-1:
      - If b<NB-1: base+=2 (mod 4), b+=1, go to FILL needing 2 rows; the new rows overwrite the two oldest physical rows.
      - If b=NB-1: base=0, b=0, go to FILL needing 4 rows (next frame).
- Latency: the handshake of the last pixel completing a band is at cycle n; tile_valid=1 with tile t=0 at cycle n+1.
- Output stability: tile_data, tile_row, tile_col and tile_last are registered and held stable while tile_valid=1 and tile_ready=0. tile_valid never drops without a handshake.
- tile_last=1 only for tile (NB-1, TPB-1).
- tile_ready is ignored while tile_valid=0. pix_valid is ignored outside FILL. Pixels are never dropped and never double-written.
- Reset (any time, including mid-fill or mid-emit) clears:
  - state=FILL needing 4 rows
  - base=0, all counters 0
  - tile_valid=0, tile_last=0, tile_data=0, tile_row=0, tile_col=0
  - pix_ready=0 while rst=1
- A partial frame at reset is discarded; line-buffer contents need not be cleared.
- Index widths: tile_row/tile_col are zero-extended to 8 bits; IMG_W, IMG_H <= 512.

Decomposition:
- Shared package winograd_pkg:
  - Constants TILE_N=4, TILE_STRIDE=2, and the element index function (4*i+j).
  - W default, so the data-transform stage and this block share one packing definition.
- One sub-module, winograd_line_buffer:
  - 4-row register/RAM array.
  - One write port (row, col, data).
  - Combinational 4x4 window read at (base, col) returning packed 16*W.
  - The FSM and counters stay in winograd_tile_extractor.

Test Plan:
- IMG_W=IMG_H=6, pixel value = 16*r+c, tile_ready held 1 -> exactly 4 tiles, in the order (0,0),(0,1),(1,0),(1,1).
  - Tile (0,0): elements (0,0)=0x00, (3,3)=0x33.
  - Tile (0,1): (0,0)=0x02, (3,3)=0x35.
  - Tile (1,0): (0,0)=0x20, (3,3)=0x53.
  - tile_last=1 only on (1,1).
- Same frame, tile_ready toggled pseudo-randomly -> identical tile sequence. tile_data stable across every stalled cycle. pix_ready=0 throughout EMIT.
- Latency check -> tile_valid rises exactly one cycle after the 24th accepted pixel (row 3, col 5). The second band's first tile appears one cycle after the 36th pixel.
- Two back-to-back frames with pix_valid gaps -> the second frame's tiles match the first's values offset by the pattern change. Base pointer wrap (rows 4,5 stored in physical rows 0,1) is verified via tile (1,0) contents.
- rst pulsed mid-EMIT after tile (0,0) -> outputs return to 0 asynchronously. The next frame restarts at tile (0,0) with correct contents.
- rst pulsed mid-FILL after 10 pixels -> those pixels are discarded. The following full frame yields correct tiles.
